pjw_arbiter: RTL and testbench

PJW_ARBITER -- requirements
Module: pjw_arbiter

---
 rtl/pjw_arb_pkg.sv | 23 ++
 rtl/pjw_arbiter_if.sv | 39 +++
 rtl/pjw_arbiter_rr_picker.sv | 38 +++
 rtl/pjw_arbiter.sv | 171 +++++++++++++++++
 tb/tb_pjw_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pjw_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pjw_arb_pkg                                                  |
// | Description : Shared types and constants for the pjw hash-core arbiter:    |
// |               FSM state encoding, default requester count, default         |
// |               watchdog limit and the hash result width.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pjw_arb_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 15;
  localparam int RES_W           = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage : pjw_arb_pkg
`default_nettype wire

// File: rtl/pjw_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pjw_arbiter_if                                               |
// | Description : Bundle of requester-side and core-side signals of the pjw    |
// |               arbiter.                                                     |
// |   slave  modport : arbiter view (requests/core status in, grants out)      |
// |   master modport : environment view (requesters plus hash core)            |
// |   req_valid/req_data   per-requester request strobe and word              |
// |   req_ready            one-hot accept pulse                                |
// |   resp_valid           one-hot result strobe; resp_data/resp_err result    |
// |   core_valid/core_data job issue to the core                               |
// |   core_ready/core_result core status and result                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pjw_arbiter_if #(
  parameter int NUM_REQ = pjw_arb_pkg::NUM_REQ_DEF
);
  logic [NUM_REQ-1:0]                         req_valid;
  logic [NUM_REQ-1:0][pjw_arb_pkg::RES_W-1:0] req_data;
  logic [NUM_REQ-1:0]                         req_ready;
  logic [NUM_REQ-1:0]                         resp_valid;
  logic [pjw_arb_pkg::RES_W-1:0]              resp_data;
  logic                                       resp_err;
  logic                                       core_valid;
  logic [pjw_arb_pkg::RES_W-1:0]              core_data;
  logic                                       core_ready;
  logic [pjw_arb_pkg::RES_W-1:0]              core_result;

  modport slave (
    input  req_valid, req_data, core_ready, core_result,
    output req_ready, resp_valid, resp_data, resp_err, core_valid, core_data
  );

  modport master (
    output req_valid, req_data, core_ready, core_result,
    input  req_ready, resp_valid, resp_data, resp_err, core_valid, core_data
  );
endinterface : pjw_arbiter_if
`default_nettype wire

// File: rtl/pjw_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_picker                                                    |
// | Description : Combinational round-robin winner selection. Priority starts  |
// |               at (ptr + 1) mod N and wraps around.                         |
// |   req     : request vector                                                 |
// |   ptr     : index granted last                                             |
// |   gnt_any : at least one request present                                   |
// |   gnt_idx : winning index (0 when gnt_any is low)                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_any,
  output logic [IDX_W-1:0] gnt_idx
);

  // Walk from lowest to highest priority so the highest-priority hit is the
  // last assignment and wins.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_any = |req;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) begin
        gnt_idx = IDX_W'(cand);
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/pjw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pjw_arbiter                                                  |
// | Description : Shares one pjw hash core between NUM_REQ requesters with     |
// |               round-robin grant, one job outstanding at a time.            |
// |   clk : clock (rising edge)                                                |
// |   rst : asynchronous active-high reset                                     |
// |   bus : pjw_arbiter_if.slave (requester and core handshakes)               |
// |   Optional macro PJW_ARB_TIMEOUT_EN enables the WAIT-state watchdog that   |
// |   aborts a job after TIMEOUT_CYC cycles with resp_err=1, resp_data=0.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pjw_arbiter
  import pjw_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  pjw_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("pjw_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC must be >= 1");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [RES_W-1:0]   data_q, data_d;
  logic [RES_W-1:0]   resp_data_q, resp_data_d;
  logic               busy_seen_q, busy_seen_d;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [NUM_REQ-1:0] resp_valid_c;

`ifdef PJW_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            resp_err_q, resp_err_d;
`endif

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt_any (pick_any),
    .gnt_idx (pick_idx)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      busy_seen_q <= 1'b0;
`ifdef PJW_ARB_TIMEOUT_EN
      wd_q        <= '0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      data_q      <= data_d;
      resp_data_q <= resp_data_d;
      busy_seen_q <= busy_seen_d;
`ifdef PJW_ARB_TIMEOUT_EN
      wd_q        <= wd_d;
      resp_err_q  <= resp_err_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    data_d      = data_q;
    resp_data_d = resp_data_q;
    busy_seen_d = busy_seen_q;
`ifdef PJW_ARB_TIMEOUT_EN
    wd_d        = wd_q;
    resp_err_d  = resp_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          ptr_d   = pick_idx;
          owner_d = pick_idx;
          data_d  = bus.req_data[pick_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef PJW_ARB_TIMEOUT_EN
        wd_d = '0;
`endif
        if (bus.core_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // core_ready is still high from the idle phase right after accept
        // on some cores; only a ready after a busy phase marks the result.
`ifdef PJW_ARB_TIMEOUT_EN
        wd_d = wd_q + 1'b1;
`endif
        if (!bus.core_ready) begin
          busy_seen_d = 1'b1;
        end
        if (bus.core_ready && busy_seen_q) begin
          resp_data_d = bus.core_result;
          busy_seen_d = 1'b0;
          state_d     = ST_RESP;
`ifdef PJW_ARB_TIMEOUT_EN
          resp_err_d  = 1'b0;
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = ST_RESP;
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    req_ready_c  = '0;
    resp_valid_c = '0;
    // The grant pulse is combinational from the request vector; masking it
    // during reset keeps a requester from seeing an accept that never latches.
    if (state_q == ST_IDLE && pick_any && !rst) begin
      req_ready_c[pick_idx] = 1'b1;
    end
    if (state_q == ST_RESP) begin
      resp_valid_c[owner_q] = 1'b1;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_data  = resp_data_q;
  assign bus.core_valid = (state_q == ST_ISSUE);
  assign bus.core_data  = data_q;
`ifdef PJW_ARB_TIMEOUT_EN
  assign bus.resp_err   = resp_err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule : pjw_arbiter
`default_nettype wire

// File: tb/tb_pjw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pjw_arbiter                                               |
// | Description : Scoreboard bench for pjw_arbiter with a 5-cycle pjw core     |
// |               model. Directed jobs push expected grants and results; a     |
// |               negedge monitor pops and compares on req_ready/resp_valid.   |
// |               Define PJW_ARB_TIMEOUT_EN to add the watchdog scenario.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pjw_arbiter;

  localparam int NREQ = 4;
  localparam int TOUT = 15;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  pjw_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  pjw_arbiter #(
    .NUM_REQ     (NREQ),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   n_resp = 0;
  int   cyc = 0;
  int   grant_q[$];
  int   gcyc_q[$];
  exp_t resp_q[$];
  int   rep[NREQ];
  logic core_stall;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference pjw (ELF) hash over the 4 bytes of a word, MSB first.
  function automatic logic [31:0] pjw(input logic [31:0] w);
    logic [31:0] h;
    logic [31:0] g;
    h = '0;
    for (int b = 3; b >= 0; b--) begin
      h = (h << 4) + {24'd0, w[b*8 +: 8]};
      g = h & 32'hF000_0000;
      if (g != 0) h = h ^ (g >> 24);
      h = h & ~g;
    end
    return h;
  endfunction

  // Core model: accepts on valid&ready, busy for 5 cycles, then ready with result.
  initial begin
    logic        s_valid, s_ready;
    logic [31:0] s_data, acc;
    int          cnt;
    bus.core_ready  = 1'b1;
    bus.core_result = '0;
    cnt = 0;
    acc = '0;
    forever begin
      @(negedge clk);
      s_valid = bus.core_valid;
      s_ready = bus.core_ready;
      s_data  = bus.core_data;
      @(posedge clk);
      #1;
      if (rst) begin
        bus.core_ready = 1'b1;
        cnt = 0;
      end else if (s_valid && s_ready) begin
        bus.core_ready = 1'b0;
        cnt = 5;
        acc = pjw(s_data);
      end else if (cnt > 0 && !core_stall) begin
        if (cnt == 1) begin
          bus.core_ready  = 1'b1;
          bus.core_result = acc;
        end
        cnt--;
      end
    end
  end

  // Requester drivers: hold req_valid until accepted, optionally re-request.
  initial forever begin
    logic [NREQ-1:0] acc_r;
    @(negedge clk);
    acc_r = bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_r[i]) begin
        if (rep[i] > 0) rep[i]--;
        else bus.req_valid[i] = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial forever begin
    int   gi;
    exp_t e;
    @(negedge clk);
    if (rst) continue;
    if (bus.req_ready != '0) begin
      gi = 0;
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gi = i;
      chk("req_ready_onehot", $countones(bus.req_ready), 1);
      chk("single_outstanding", gcyc_q.size(), 0);
      if (grant_q.size() == 0) begin
        chk("unexpected_grant", gi, 32'hFFFF_FFFF);
      end else begin
        chk("grant_idx", gi, grant_q.pop_front());
      end
      gcyc_q.push_back(cyc);
    end
    if (bus.resp_valid != '0) begin
      n_resp++;
      gi = 0;
      for (int i = 0; i < NREQ; i++) if (bus.resp_valid[i]) gi = i;
      chk("resp_valid_onehot", $countones(bus.resp_valid), 1);
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", gi, 32'hFFFF_FFFF);
      end else begin
        e = resp_q.pop_front();
        chk("resp_idx", gi, e.idx);
        chk("resp_data", bus.resp_data, e.data);
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        if (gcyc_q.size() == 0) chk("resp_without_grant", 1, 0);
        else chk("latency", cyc - gcyc_q.pop_front(), e.lat);
      end
    end
  end

  task automatic expect_job(input int idx, input logic [31:0] data, input logic err, input int lat);
    exp_t e;
    e.idx = idx; e.data = data; e.err = err; e.lat = lat;
    grant_q.push_back(idx);
    resp_q.push_back(e);
  endtask

  task automatic req(input int i, input logic [31:0] d, input int repeats);
    rep[i]           = repeats;
    bus.req_data[i]  = d;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_req_ready"},  {28'd0, bus.req_ready}, 32'd0);
    chk({nm, "_resp_valid"}, {28'd0, bus.resp_valid}, 32'd0);
    chk({nm, "_resp_data"},  bus.resp_data, 32'd0);
    chk({nm, "_resp_err"},   {31'd0, bus.resp_err}, 32'd0);
    chk({nm, "_core_valid"}, {31'd0, bus.core_valid}, 32'd0);
    chk({nm, "_core_data"},  bus.core_data, 32'd0);
  endtask

  task automatic wait_done(input string nm, input int max_cyc);
    int n;
    n = 0;
    while ((grant_q.size() != 0 || resp_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (grant_q.size() != 0 || resp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: pending grants=%0d resps=%0d after %0d cycles",
               nm, grant_q.size(), resp_q.size(), max_cyc);
      grant_q.delete();
      resp_q.delete();
      gcyc_q.delete();
    end
  endtask

  initial begin
    int snap;
    rst             = 1'b1;
    core_stall      = 1'b0;
    bus.req_valid   = '0;
    bus.req_data    = '0;
    for (int i = 0; i < NREQ; i++) rep[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #2 rst = 1'b0;

    // Single request on 0: hash of 0x41 is 0x41, 8-cycle latency.
    @(posedge clk); #2;
    expect_job(0, 32'h0000_0041, 1'b0, 8);
    req(0, 32'h0000_0041, 0);
    wait_done("t1", 40);

    // Single request on 2: "ABCD" hashes to 0x00045674.
    @(posedge clk); #2;
    expect_job(2, 32'h0004_5674, 1'b0, 8);
    req(2, 32'h4142_4344, 0);
    wait_done("t2", 40);

    // All four valid through reset: pointer restarts, order 0,1,2,3.
    @(posedge clk); #2 rst = 1'b1;
    req(0, 32'h0000_0010, 0);
    req(1, 32'h0000_0021, 0);
    req(2, 32'h0000_0032, 0);
    req(3, 32'h0000_0043, 0);
    expect_job(0, 32'h0000_0010, 1'b0, 8);
    expect_job(1, 32'h0000_0021, 1'b0, 8);
    expect_job(2, 32'h0000_0032, 1'b0, 8);
    expect_job(3, 32'h0000_0043, 1'b0, 8);
    @(negedge clk);
    check_reset("rst_with_req");
    @(posedge clk); #2 rst = 1'b0;
    wait_done("t3", 100);

    // Requester 1 re-requests continuously while 3 pends: 1,3,1,3,1.
    @(posedge clk); #2;
    req(1, 32'h0000_0011, 2);
    req(3, 32'h0000_0055, 1);
    expect_job(1, 32'h0000_0011, 1'b0, 8);
    expect_job(3, 32'h0000_0055, 1'b0, 8);
    expect_job(1, 32'h0000_0011, 1'b0, 8);
    expect_job(3, 32'h0000_0055, 1'b0, 8);
    expect_job(1, 32'h0000_0011, 1'b0, 8);
    wait_done("t4", 120);

    // Reset during WAIT discards the job.
    @(posedge clk); #2;
    expect_job(0, 32'h0000_0077, 1'b0, 8);
    req(0, 32'h0000_0077, 0);
    for (int n = 0; n < 20 && grant_q.size() != 0; n++) @(negedge clk);
    chk("t5_granted", grant_q.size(), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    snap = n_resp;
    @(negedge clk);
    check_reset("mid_job");
    @(posedge clk); #2 rst = 1'b0;
    grant_q.delete();
    resp_q.delete();
    gcyc_q.delete();
    repeat (12) @(posedge clk);
    chk("no_resp_after_abort", n_resp - snap, 0);
    #2;
    expect_job(2, 32'h0000_0154, 1'b0, 8);
    req(2, 32'h0000_1234, 0);
    wait_done("t5", 40);

`ifdef PJW_ARB_TIMEOUT_EN
    // Core never finishes: watchdog aborts after TOUT cycles in WAIT.
    @(posedge clk); #2;
    core_stall = 1'b1;
    expect_job(3, 32'h0000_0000, 1'b1, TOUT + 2);
    req(3, 32'h0000_0099, 0);
    wait_done("t6", TOUT + 30);
    @(posedge clk); #2 rst = 1'b1;
    core_stall = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
`endif

    repeat (3) @(posedge clk);
    chk("queues_empty", grant_q.size() + resp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_pjw_arbiter
`default_nettype wire
